// File: rtl/riscv_pkg.sv
// Shared constants for the writeback path: data/address widths, requester ids
// and the hard-wired zero register.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

    localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input grant for the writeback port: round-robin on a last-grant pointer,
// or fixed priority to the memory requester when RR_EN is 0.
module rr_arbiter2
    import riscv_pkg::*;
#(
    parameter int unsigned RR_EN = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req_alu,
    input  logic i_req_mem,
    output logic o_gnt_alu,
    output logic o_gnt_mem
);

    req_id_e r_last_grant;

    // Grants are suppressed during reset so nothing is accepted while rst=1.
    always_comb begin
        o_gnt_alu = 1'b0;
        o_gnt_mem = 1'b0;
        if (!rst) begin
            if (i_req_alu && i_req_mem) begin
                if ((RR_EN != 0) && (r_last_grant == REQ_MEM)) begin
                    o_gnt_alu = 1'b1;
                end else begin
                    o_gnt_mem = 1'b1;
                end
            end else begin
                o_gnt_alu = i_req_alu;
                o_gnt_mem = i_req_mem;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= REQ_ALU;
        end else if (RR_EN != 0) begin
            if (o_gnt_mem) begin
                r_last_grant <= REQ_MEM;
            end else if (o_gnt_alu) begin
                r_last_grant <= REQ_ALU;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register file write port between the ALU and load writeback paths,
// with a registered output stage and pending-write hit flags for decode bypass.
module wb_port_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned RR_EN = 1,
    parameter int unsigned XLEN  = riscv_pkg::XLEN,
    parameter int unsigned AW    = riscv_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    output logic            we3,
    output logic [AW-1:0]   a3,
    output logic [XLEN-1:0] wd3,
    input  logic [AW-1:0]   q1,
    input  logic [AW-1:0]   q2,
    output logic            hit1,
    output logic            hit2
);

    logic            w_gnt_alu;
    logic            w_gnt_mem;
    logic            r_we3;
    logic [AW-1:0]   r_a3;
    logic [XLEN-1:0] r_wd3;

    rr_arbiter2 #(
        .RR_EN(RR_EN)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req_alu(alu_valid),
        .i_req_mem(mem_valid),
        .o_gnt_alu(w_gnt_alu),
        .o_gnt_mem(w_gnt_mem)
    );

    assign alu_ready = w_gnt_alu;
    assign mem_ready = w_gnt_mem;

    // x0 writes are accepted and captured but never enable the write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we3 <= 1'b0;
            r_a3  <= '0;
            r_wd3 <= '0;
        end else if (w_gnt_mem) begin
            r_we3 <= (mem_rd != AW'(REG_ZERO));
            r_a3  <= mem_rd;
            r_wd3 <= mem_data;
        end else if (w_gnt_alu) begin
            r_we3 <= (alu_rd != AW'(REG_ZERO));
            r_a3  <= alu_rd;
            r_wd3 <= alu_data;
        end else begin
            r_we3 <= 1'b0;
        end
    end

    assign we3  = r_we3;
    assign a3   = r_a3;
    assign wd3  = r_wd3;
    assign hit1 = r_we3 && (r_a3 == q1) && (q1 != AW'(REG_ZERO));
    assign hit2 = r_we3 && (r_a3 == q2) && (q2 != AW'(REG_ZERO));

endmodule
